// File: rtl/blake2_msg_pack.sv
// blake2_msg_pack: byte stream to blake2 block feeder (key block, zero padding, ll, hold timing).
// Optional protocol error checks enabled by defining BLAKE2_PACK_ERR_EN.
module blake2_msg_pack #(
  parameter int W        = 32,
  parameter int R        = 10,
  parameter int HOLD_CYC = 8*R+1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [7:0]  s_data_i,
  input  logic        s_last_i,
  input  logic        s_empty_i,
  input  logic        core_h_v_i,
  output logic        data_v_o,
  output logic [5:0]  data_idx_o,
  output logic [7:0]  data_o,
  output logic        block_first_o,
  output logic        block_last_o,
  output logic [5:0]  kk_o,
  output logic [5:0]  nn_o,
  output logic [63:0] ll_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int HW = $clog2(HOLD_CYC+1);
  typedef enum logic [2:0] {IDLE, KEY, MSG, PAD, HOLD, WAIT_RES} state_t;
  state_t state;
  logic [5:0] cnt, kk_e;
  logic [HW-1:0] hcnt;
  logic fin, f1, seen_h;
  logic idle, acc, key_ph, nobyte, fin_n, blk_end, emit;
  assign idle = state == IDLE;
  assign s_ready_o = idle || state == KEY || state == MSG;
  assign acc = s_valid_i & s_ready_o;
  assign kk_e = idle ? kk_i : kk_o;
  assign key_ph = state == KEY || (idle && kk_i != 6'd0);
  // an empty final beat on the message path carries no byte
  assign nobyte = !key_ph && s_empty_i && s_last_i;
  assign fin_n = fin | (acc & s_last_i);
  assign blk_end = cnt == 6'(2*W-1);
  assign emit = (acc && !nobyte) || state == PAD;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt <= '0;
      hcnt <= '0;
      fin <= 1'b0;
      f1 <= 1'b0;
      seen_h <= 1'b0;
      data_v_o <= 1'b0;
      data_idx_o <= '0;
      data_o <= '0;
      block_first_o <= 1'b0;
      block_last_o <= 1'b0;
      kk_o <= '0;
      nn_o <= '0;
      ll_o <= '0;
      busy_o <= 1'b0;
    end else begin
      data_v_o <= emit;
      if (emit) begin
        data_idx_o <= cnt;
        data_o <= state == PAD ? 8'd0 : s_data_i;
        block_first_o <= idle | f1;
        block_last_o <= fin_n;
        cnt <= cnt + 6'd1;
      end
      f1 <= (idle & acc) | (f1 & ~(emit & blk_end));
      fin <= fin_n;
      if (idle && acc) begin
        kk_o <= kk_i;
        nn_o <= nn_i;
        busy_o <= 1'b1;
        ll_o <= kk_i != 6'd0 ? 64'(2*W) : {63'd0, ~nobyte};
      end else if (state == MSG && acc && !nobyte)
        ll_o <= ll_o + 64'd1;
      case (state)
        IDLE, KEY, MSG: if (acc)
          state <= key_ph ? (cnt == kk_e - 6'd1 ? PAD : KEY)
                 : s_last_i ? (blk_end && !nobyte ? WAIT_RES : PAD)
                 : blk_end ? HOLD : MSG;
        PAD: if (blk_end) state <= fin ? WAIT_RES : HOLD;
        HOLD: if (hcnt == '0) state <= MSG;
        WAIT_RES: if (seen_h && !core_h_v_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      hcnt <= state == HOLD ? hcnt - 1'b1 : HW'(HOLD_CYC - 1);
      seen_h <= state == WAIT_RES && (seen_h | core_h_v_i);
      if (state == WAIT_RES && seen_h && !core_h_v_i) begin
        busy_o <= 1'b0;
        fin <= 1'b0;
      end
    end
  end
`ifdef BLAKE2_PACK_ERR_EN
  logic err_n;
  assign err_n = (idle && (kk_i > 6'd32 || nn_i == 6'd0 || nn_i > 6'd32))
              || (s_empty_i && (kk_e != 6'd0 || !s_last_i))
              || (key_ph && s_last_i && cnt != kk_e - 6'd1);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) err_o <= 1'b0;
    else if (acc) err_o <= (idle ? 1'b0 : err_o) | err_n;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_blake2_msg_pack.sv
// tb_blake2_msg_pack: table-driven message cases with a byte scoreboard, plus reset and error sequences.
module tb_blake2_msg_pack;
  localparam int HOLD_CYC = 81;
`ifdef BLAKE2_PACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic clk = 0, nreset = 0;
  logic [5:0] kk_i = 0, nn_i = 0;
  logic s_valid_i = 0, s_last_i = 0, s_empty_i = 0, core_h_v_i = 0;
  logic [7:0] s_data_i = 0;
  logic s_ready_o, data_v_o, block_first_o, block_last_o, busy_o, err_o;
  logic [5:0] data_idx_o, kk_o, nn_o;
  logic [7:0] data_o;
  logic [63:0] ll_o;

  blake2_msg_pack dut (
    .clk(clk), .nreset(nreset), .kk_i(kk_i), .nn_i(nn_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .s_empty_i(s_empty_i), .core_h_v_i(core_h_v_i),
    .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o),
    .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [5:0] idx; logic [7:0] d; logic f; logic l; logic nb;} exp_t;
  typedef struct {int kk; int nn; int len; logic [7:0] d0; logic [7:0] st; bit bub; bit hold; logic [63:0] ll; int beats;} vec_t;
  exp_t q[$];
  vec_t tv[9];
  int checks = 0, errors = 0, cyc = 0, nbeats = 0, last63 = 0;
  bit chk_hold = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nreset && data_v_o) begin
      nbeats++;
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("idx", data_idx_o, e.idx);
        chk("data", data_o, e.d);
        chk("first", block_first_o, e.f);
        chk("last", block_last_o, e.l);
        if (e.nb && chk_hold) chk("hold_gap", cyc - last63 - 1, HOLD_CYC);
        if (e.idx == 6'd63) last63 = cyc;
      end
    end
  end

  // Reference model: key block, message blocks (or one zero block for an empty message)
  task automatic expect_msg(input int kk, input int len, input logic [7:0] d0, input logic [7:0] st);
    exp_t e;
    int nb = (len + 63) / 64;
    int blk = 0;
    if (kk > 0) begin
      for (int i = 0; i < 64; i++) begin
        e.idx = 6'(i); e.d = i < kk ? 8'(i) : 8'd0; e.f = 1; e.l = len == 0 && i >= kk - 1; e.nb = 0;
        q.push_back(e);
      end
      blk = 1;
    end
    if (len == 0 && kk == 0)
      for (int i = 0; i < 64; i++) begin
        e.idx = 6'(i); e.d = 0; e.f = 1; e.l = 1; e.nb = 0;
        q.push_back(e);
      end
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 64; i++) begin
        int p = b * 64 + i;
        e.idx = 6'(i); e.d = p < len ? 8'(d0 + p * st) : 8'd0;
        e.f = (blk + b) == 0; e.l = b == nb - 1 && p >= len - 1; e.nb = i == 0 && blk + b > 0;
        q.push_back(e);
      end
  endtask

  task automatic put(input logic [7:0] d, input logic l, input logic em, input bit bub);
    int t = 0;
    if (bub) while ($urandom_range(0, 2) == 0) begin s_valid_i = 0; @(posedge clk); #1; end
    s_valid_i = 1; s_data_i = d; s_last_i = l; s_empty_i = em;
    while (!s_ready_o && t <= 2000) begin @(posedge clk); #1; t++; end
    chk("ready_timeout", t > 2000, 0);
    @(posedge clk); #1;
    s_valid_i = 0;
  endtask

  task automatic run_msg(input int kk, input int nn, input int len, input logic [7:0] d0, input logic [7:0] st,
                         input bit bub, input logic [63:0] exp_ll, input int exp_beats);
    int t = 0;
    nbeats = 0;
    expect_msg(kk, len, d0, st);
    kk_i = 6'(kk); nn_i = 6'(nn);
    for (int i = 0; i < kk; i++) put(8'(i), len == 0 && i == kk - 1, 0, bub);
    if (len == 0 && kk == 0) put(8'd0, 1, 1, bub);
    for (int i = 0; i < len; i++) put(8'(d0 + i * st), i == len - 1, 0, bub);
    while (q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
    chk("beats", nbeats, exp_beats);
    chk("ll", ll_o, exp_ll);
    chk("kk", kk_o, kk);
    chk("nn", nn_o, nn);
    chk("busy", busy_o, 1);
    chk("ready_wait", s_ready_o, 0);
    core_h_v_i = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("ready_hv", s_ready_o, 0);
    core_h_v_i = 0;
    @(posedge clk); #1;
    chk("ready_idle", s_ready_o, 1);
    chk("busy_idle", busy_o, 0);
  endtask

  initial begin
    tv[0] = '{0, 32, 3, 8'h61, 8'h01, 0, 0, 64'd3, 64};
    tv[1] = '{0, 32, 0, 8'h00, 8'h00, 0, 0, 64'd0, 64};
    tv[2] = '{32, 32, 0, 8'h00, 8'h00, 0, 0, 64'd64, 64};
    tv[3] = '{0, 32, 64, 8'h05, 8'h03, 0, 0, 64'd64, 64};
    tv[4] = '{0, 32, 65, 8'h11, 8'h07, 0, 1, 64'd65, 128};
    tv[5] = '{0, 32, 65, 8'h11, 8'h07, 1, 0, 64'd65, 128};
    tv[6] = '{16, 20, 10, 8'h80, 8'h05, 0, 1, 64'd74, 128};
    tv[7] = '{1, 1, 0, 8'h00, 8'h00, 0, 0, 64'd64, 64};
    tv[8] = '{0, 16, 130, 8'h3c, 8'h0b, 0, 1, 64'd130, 192};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {data_v_o, data_idx_o, data_o, block_first_o, block_last_o, kk_o, nn_o, busy_o, err_o}, 0);
    chk("rst_ll", ll_o, 0);
    nreset = 1;
    @(posedge clk); #1;
    chk("rst_ready", s_ready_o, 1);
    for (int k = 0; k < 9; k++) begin
      chk_hold = tv[k].hold;
      run_msg(tv[k].kk, tv[k].nn, tv[k].len, tv[k].d0, tv[k].st, tv[k].bub, tv[k].ll, tv[k].beats);
    end
    chk_hold = 0;
    // abort mid-block with an asynchronous reset just after byte 20 is emitted
    kk_i = 0; nn_i = 32;
    expect_msg(0, 65, 8'h10, 8'h03);
    for (int i = 0; i < 21; i++) put(8'(8'h10 + i * 3), 0, 0, 0);
    @(negedge clk); #1;
    chk("pre_rst_idx", data_idx_o, 20);
    nreset = 0;
    #1;
    chk("async_rst_outs", {data_v_o, data_idx_o, data_o, block_first_o, block_last_o, kk_o, nn_o, busy_o, err_o}, 0);
    chk("async_rst_ll", ll_o, 0);
    @(posedge clk); #1;
    chk("rst_edge_outs", {data_v_o, data_idx_o, data_o, block_first_o, block_last_o, busy_o}, 0);
    q.delete();
    nreset = 1;
    @(posedge clk); #1;
    run_msg(0, 32, 3, 8'h61, 8'h01, 0, 64'd3, 64);
    // nn=0 flags an error when checks are built in, and the next start clears it
    run_msg(0, 0, 3, 8'h61, 8'h01, 0, 64'd3, 64);
    chk("err_nn0", err_o, ERR_EN);
    run_msg(0, 32, 5, 8'h20, 8'h01, 0, 64'd5, 64);
    chk("err_cleared", err_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
